disp_vramrd: RTL



---
 rtl/disp_vramrd_if.sv | 26 ++
 rtl/disp_vramrd.sv | 106 ++++++++++
 2 files changed

// File: rtl/disp_vramrd_if.sv
// AXI read-address/read-data channels plus the line-FIFO write port of the display VRAM reader.
// master = the reader (drives AR/RREADY/FIFO write); slave = memory and FIFO side.
interface disp_vramrd_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        FIFOWR;
    logic [31:0] FIFOIN;
    logic        FIFOAFULL;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY, FIFOWR, FIFOIN,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID, FIFOAFULL
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY, FIFOWR, FIFOIN,
        output ARREADY, RDATA, RRESP, RLAST, RVALID, FIFOAFULL
    );
endinterface

// File: rtl/disp_vramrd.sv
// Display VRAM reader: fetches one frame as AXI bursts into the line FIFO (optional RRESP check: DISP_VRAMRD_RESPCHK_EN).
// Latency: AR issued two cycles after an accepted VSTART when the FIFO has room; read beats pass to FIFOWR/FIFOIN with zero latency.
// Backpressure: FIFOAFULL holds off the next burst in WAITFIFO only; AR waits on ARREADY; beats accepted only when RVALID.
module disp_vramrd #(
    parameter int BURSTLEN    = 16,
    parameter int FRAMEBURSTS = 9600
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic          VSTART,
    input  logic          DISPON,
    input  logic [31:0]   VRAMADR,
    output logic          BUSY,
    output logic          RERR,
    disp_vramrd_if.master bus
);
    localparam int          CNTW      = $clog2(FRAMEBURSTS + 1);
    localparam logic [31:0] ADR_STEP  = 32'(BURSTLEN * 4);
    localparam logic [7:0]  ARLEN_VAL = 8'(BURSTLEN - 1);

    typedef enum logic [1:0] {IDLE, WAITFIFO, ADDR, DATA} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     cur_adr;
    logic [CNTW-1:0] burst_cnt;
    logic [CNTW-1:0] burst_cnt_inc;
    logic            start;
    logic            beat;
    logic            last_beat;
    logic            frame_done;

    // beat is derived from state rather than RREADY to keep the output block acyclic
    assign start         = (state == IDLE) && VSTART && DISPON;
    assign beat          = (state == DATA) && bus.RVALID;
    assign last_beat     = beat && bus.RLAST;
    assign burst_cnt_inc = burst_cnt + 1'b1;
    assign frame_done    = (burst_cnt_inc == CNTW'(FRAMEBURSTS));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            cur_adr   <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cur_adr   <= {VRAMADR[31:6], 6'b0};
                burst_cnt <= '0;
            end else if (last_beat) begin
                cur_adr   <= cur_adr + ADR_STEP;
                burst_cnt <= burst_cnt_inc;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.ARVALID = 1'b0;
        bus.ARLEN   = '0;
        bus.RREADY  = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = WAITFIFO;
            WAITFIFO: if (!bus.FIFOAFULL) state_nxt = ADDR;
            ADDR: begin
                bus.ARVALID = 1'b1;
                bus.ARLEN   = ARLEN_VAL;
                if (bus.ARREADY) state_nxt = DATA;
            end
            DATA: begin
                bus.RREADY = 1'b1;
                if (last_beat) state_nxt = frame_done ? IDLE : WAITFIFO;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus.ARADDR = cur_adr;
    assign bus.FIFOWR = beat;
    assign bus.FIFOIN = beat ? bus.RDATA : '0;
    assign BUSY       = (state != IDLE);

`ifdef DISP_VRAMRD_RESPCHK_EN
    logic rerr_q;

    // sticky per frame: only a new accepted frame start clears it
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rerr_q <= 1'b0;
        end else if (start) begin
            rerr_q <= 1'b0;
        end else if (beat && (bus.RRESP != 2'b00)) begin
            rerr_q <= 1'b1;
        end
    end

    assign RERR = rerr_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^bus.RRESP;
    assign RERR         = 1'b0;
`endif

    logic unused_adr_lsb;
    assign unused_adr_lsb = ^VRAMADR[5:0];
endmodule
